// File: rtl/ifetch_prefetch.sv
// Instruction-fetch unit with byte prefetch FIFO and per-task PC restore.
// Optional macro IFETCH_PC_SAVE_EN enables the saved-PC table; otherwise a task switch starts at PC 0.
module ifetch_prefetch #(
  parameter int CHANNEL_BITS = 3,
  parameter int THREAD_BITS  = 1,
  parameter int PC_BITS      = 12,
  parameter int DEPTH        = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [CHANNEL_BITS-1:0]         next_task_channel,
  input  logic [THREAD_BITS-1:0]          next_task_thread,
  input  logic                            next_task_ready,
  input  logic [PC_BITS-1:0]              jump_target,
  input  logic                            jump_enable,
  output logic [CHANNEL_BITS+PC_BITS-1:0] mem_addr,
  output logic                            mem_rd_en,
  input  logic [7:0]                      mem_d_in,
  input  logic                            mem_ack,
  output logic [7:0]                      opcode,
  output logic                            opcode_valid,
  input  logic                            opcode_take,
  output logic [PC_BITS-1:0]              opcode_pc,
  output logic                            task_active
);
  localparam int AW = CHANNEL_BITS + PC_BITS;
  localparam int TW = CHANNEL_BITS + THREAD_BITS;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [CHANNEL_BITS-1:0] cur_channel, channel_nxt;
  logic [THREAD_BITS-1:0]  cur_thread, thread_nxt;
  logic [PC_BITS-1:0]      fetch_pc, pc_nxt, arch_pc, load_pc;
  logic [AW-1:0]           req_addr;
  logic [7:0]              fifo [DEPTH];
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [CW-1:0]           count, count_nxt;
  logic                    active;
  logic                    switch_go, jump_go, flush, outstanding, push, pop;

  assign switch_go   = next_task_ready;
  assign jump_go     = jump_enable && !next_task_ready && (state != IDLE);
  assign flush       = switch_go || jump_go;
  assign outstanding = ((state == FETCH) || (state == DRAIN)) && !mem_ack;
  // A redirect flushes the FIFO, so neither the arriving byte nor a same-cycle pop counts.
  assign push        = (state == FETCH) && mem_ack && !flush;
  assign pop         = opcode_take && (count != '0) && !flush;
  assign arch_pc     = fetch_pc - PC_BITS'(count);

`ifdef IFETCH_PC_SAVE_EN
  logic [PC_BITS-1:0] pc_tab [2**TW];
  logic [TW-1:0]      old_idx, new_idx;

  assign old_idx = {cur_channel, cur_thread};
  assign new_idx = {next_task_channel, next_task_thread};
  // Switching to the running task resumes from its live PC, not the stale table entry.
  assign load_pc = ((state != IDLE) && (new_idx == old_idx)) ? arch_pc : pc_tab[new_idx];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**TW; i++) pc_tab[i] <= '0;
    end else if (switch_go && (state != IDLE)) begin
      pc_tab[old_idx] <= arch_pc;
    end
  end
`else
  assign load_pc = '0;
`endif

  always_comb begin
    state_nxt   = state;
    channel_nxt = cur_channel;
    thread_nxt  = cur_thread;
    pc_nxt      = fetch_pc;
    count_nxt   = flush ? '0 : count + CW'(push) - CW'(pop);
    if (flush) begin
      if (switch_go) begin
        channel_nxt = next_task_channel;
        thread_nxt  = next_task_thread;
        pc_nxt      = load_pc;
      end else begin
        pc_nxt      = jump_target;
      end
      state_nxt = outstanding ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH: if (mem_ack) begin
          pc_nxt    = fetch_pc + 1'b1;
          state_nxt = (count_nxt < DEPTH_C) ? FETCH : WAIT;
        end
        WAIT:  if (pop) state_nxt = FETCH;
        DRAIN: if (mem_ack) state_nxt = FETCH;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cur_channel <= '0;
      cur_thread  <= '0;
      fetch_pc    <= '0;
      req_addr    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      active      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur_channel <= channel_nxt;
      cur_thread  <= thread_nxt;
      fetch_pc    <= pc_nxt;
      count       <= count_nxt;
      // DRAIN keeps presenting the abandoned request until the memory acks it.
      if (state_nxt != DRAIN) req_addr <= {channel_nxt, pc_nxt};
      if (switch_go) active <= 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem_d_in;
  end

  assign mem_rd_en    = (state == FETCH) || (state == DRAIN);
  assign mem_addr     = req_addr;
  assign opcode_valid = (count != '0);
  assign opcode       = opcode_valid ? fifo[rd_ptr] : 8'h00;
  assign opcode_pc    = arch_pc;
  assign task_active  = active;
endmodule
